data_sink: RTL and testbench

- Serial frame receiver and decoder for the 144-bit backscatter test frame that our data source transmitter emits one bit per BIT_PERIOD clocks, MSB first.
- Oversamples serial_in, hunts for the 48-bit preamble (PREAMBLE repeated 6 times), then captures the 96-bit payload.
- The payload is data2 x3, data3 x3, trailer x3, pad x3, one byte each. Each field is majority-voted bitwise across its 3 copies.
- Presents the recovered 10-bit word {data3[1:0], data2[7:0]} with valid, error and correction flags to the downstream logic/ILA.

---
 rtl/data_sink.sv | 159 +++++++++++++++
 tb/tb_data_sink.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_sink.sv
// data_sink: serial receiver and decoder for the 144-bit backscatter test frame.
//
// Samples serial_in once per bit period and looks for a 48-bit sync preamble.
// It then captures 96 payload bits (data2, data3, trailer and pad, three copies
// of each) and majority-votes every field bit by bit. The decoded word and its
// status flags are registered and announced with a one-clock data_valid pulse.
//
// Ports:
//   clock       system clock
//   reset       asynchronous, active-high reset
//   enable      receive enable; low flushes the receiver back to HUNT
//   serial_in   serial bit stream, MSB first
//   data_out    {maj(data3)[1:0], maj(data2)}, held until the next frame
//   data_valid  one-clock pulse when data_out and the flags update
//   frame_error trailer, data3 upper bits or pad failed their check
//   corrected   at least one copy disagreed with its field majority
//   busy        high while the payload is being captured
//
// state   | meaning
// HUNT    | shift samples through the 48-bit window, wait for the preamble
// PAYLOAD | shift 96 payload samples into the payload register
// DECODE  | one cycle; outputs were loaded on entry, clear the window

module data_sink #(
    parameter int          BIT_PERIOD   = 50,
    parameter int          SAMPLE_POINT = 25,
    parameter logic [7:0]  PREAMBLE     = 8'b10010010,
    parameter int          CNT_W        = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       serial_in,
    output logic [9:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       corrected,
    output logic       busy
);

    localparam logic [47:0]      SYNC_WORD    = {6{PREAMBLE}};
    localparam logic [CNT_W-1:0] LAST_PHASE   = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] SAMPLE_PHASE = CNT_W'(SAMPLE_POINT);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        DECODE  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] phase;
    logic [47:0]      window;
    logic [95:0]      payload;
    logic [6:0]       bit_cnt;

    logic        sample_now;
    logic [47:0] window_next;
    logic [95:0] payload_next;
    logic [7:0]  maj_field [0:3];
    logic [7:0]  copy_a, copy_b, copy_c;
    logic        any_diff;
    logic        dec_error;

    assign sample_now   = enable && (phase == SAMPLE_PHASE);
    assign window_next  = {window[46:0], serial_in};
    assign payload_next = {payload[94:0], serial_in};

    // The vote works on the payload as it will look after the current shift.
    // That lets the outputs load on the same edge that takes the 96th bit,
    // so data_valid is high during the DECODE cycle itself.
    // The field index f runs 0..3 for data2, data3, trailer and pad. The first
    // copy of each field was received first, so it sits highest.
    always_comb begin
        any_diff = 1'b0;
        copy_a   = 8'h00;
        copy_b   = 8'h00;
        copy_c   = 8'h00;
        for (int f = 0; f < 4; f++) begin
            maj_field[f] = 8'h00;
        end
        for (int f = 0; f < 4; f++) begin
            copy_a       = payload_next[95 - 24*f -: 8];
            copy_b       = payload_next[87 - 24*f -: 8];
            copy_c       = payload_next[79 - 24*f -: 8];
            maj_field[f] = (copy_a & copy_b) | (copy_a & copy_c) | (copy_b & copy_c);
            any_diff     = any_diff | (|((copy_a ^ maj_field[f]) |
                                         (copy_b ^ maj_field[f]) |
                                         (copy_c ^ maj_field[f])));
        end
    end

    assign dec_error = (maj_field[2] != PREAMBLE) ||
                       (maj_field[1][7:2] != 6'd0) ||
                       (maj_field[3] != 8'h00);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            phase       <= '0;
            window      <= '0;
            payload     <= '0;
            bit_cnt     <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            corrected   <= 1'b0;
            busy        <= 1'b0;
        end else if (!enable) begin
            // data_out and the flags keep the last decoded frame
            state      <= HUNT;
            phase      <= '0;
            window     <= '0;
            payload    <= '0;
            bit_cnt    <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            phase      <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
            data_valid <= 1'b0;
            case (state)
                HUNT: begin
                    if (sample_now) begin
                        window <= window_next;
                        if (window_next == SYNC_WORD) begin
                            state   <= PAYLOAD;
                            busy    <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (sample_now) begin
                        payload <= payload_next;
                        bit_cnt <= bit_cnt + 7'd1;
                        if (bit_cnt == 7'd95) begin
                            state       <= DECODE;
                            busy        <= 1'b0;
                            data_valid  <= 1'b1;
                            data_out    <= {maj_field[1][1:0], maj_field[0]};
                            frame_error <= dec_error;
                            corrected   <= any_diff;
                        end
                    end
                end
                DECODE: begin
                    state   <= HUNT;
                    window  <= '0;
                    payload <= '0;
                    bit_cnt <= '0;
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_sink.sv
// Directed testbench for data_sink. Cycle n starts 1 time unit after a rising
// edge. Inputs are driven there, and outputs are sampled on the falling edge
// inside the same cycle.
module tb_data_sink;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       serial_in;
    logic [9:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       corrected;
    logic       busy;

    always #5 clock = ~clock;

    data_sink dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_error(frame_error),
        .corrected  (corrected),
        .busy       (busy)
    );

    localparam logic [7:0] PRE = 8'b10010010;
    localparam int NEVER = 1000000;

    int vectors     = 0;
    int miscompares = 0;

    logic       stream [0:255];
    int         stream_len;
    logic       busy_hist [0:12999];
    int         valid_cnt;
    int         valid_cyc;
    logic [9:0] v_data;
    logic       v_err;
    logic       v_cor;

    task automatic clear_stream();
        stream_len = 0;
    endtask

    task automatic push_bit(input logic b);
        stream[stream_len] = b;
        stream_len++;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) push_bit(b[i]);
    endtask

    task automatic push_frame(input logic [7:0] d2a, input logic [7:0] d2b,
                              input logic [7:0] d2c, input logic [7:0] d3,
                              input logic [7:0] tr1, input logic [7:0] tr2,
                              input logic [7:0] tr3, input logic [7:0] pad);
        for (int i = 0; i < 6; i++) push_byte(PRE);
        push_byte(d2a); push_byte(d2b); push_byte(d2c);
        for (int i = 0; i < 3; i++) push_byte(d3);
        push_byte(tr1); push_byte(tr2); push_byte(tr3);
        for (int i = 0; i < 3; i++) push_byte(pad);
    endtask

    task automatic idle(input int n);
        enable    = 1'b0;
        serial_in = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Enable rises in cycle 0. Enable is low in cycles [abort_at, restart_at).
    // The stream starts over at restart_at.
    task automatic run_stream(input int ncycles, input int abort_at, input int restart_at);
        int rel;
        int idx;
        valid_cnt = 0;
        valid_cyc = -1;
        for (int c = 0; c < ncycles; c++) begin
            enable    = !(c >= abort_at && c < restart_at);
            rel       = (c >= restart_at) ? c - restart_at : c;
            idx       = rel / 50;
            serial_in = (idx < stream_len) ? stream[idx] : 1'b0;
            @(negedge clock);
            if (c < 13000) busy_hist[c] = busy;
            if (data_valid === 1'b1) begin
                valid_cnt++;
                valid_cyc = c;
                v_data    = data_out;
                v_err     = frame_error;
                v_cor     = corrected;
            end
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; serial_in = 1'b0;
        #12;
        vectors++; if (data_out !== 10'h000) begin miscompares++; $display("FAIL reset_data_out got %h want 000", data_out); end
        vectors++; if (data_valid !== 1'b0) begin miscompares++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
        vectors++; if (frame_error !== 1'b0) begin miscompares++; $display("FAIL reset_frame_error got %b want 0", frame_error); end
        vectors++; if (corrected !== 1'b0) begin miscompares++; $display("FAIL reset_corrected got %b want 0", corrected); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        @(posedge clock); #1;
        reset = 1'b0;
        idle(3);
        vectors++; if (busy !== 1'b0 || data_valid !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset busy %b valid %b want 0 0", busy, data_valid); end
    endtask

    task automatic test_nominal();
        clear_stream();
        push_frame(8'hAA, 8'hAA, 8'hAA, 8'h02, PRE, PRE, PRE, 8'h00);
        run_stream(7250, NEVER, NEVER);
        idle(2);
        vectors++; if (valid_cnt !== 1) begin miscompares++; $display("FAIL nom_valid_count got %0d want 1", valid_cnt); end
        vectors++; if (valid_cyc !== 7176) begin miscompares++; $display("FAIL nom_valid_cycle got %0d want 7176", valid_cyc); end
        vectors++; if (v_data !== 10'h2AA) begin miscompares++; $display("FAIL nom_data_out got %h want 2aa", v_data); end
        vectors++; if (v_err !== 1'b0) begin miscompares++; $display("FAIL nom_frame_error got %b want 0", v_err); end
        vectors++; if (v_cor !== 1'b0) begin miscompares++; $display("FAIL nom_corrected got %b want 0", v_cor); end
        vectors++; if (busy_hist[2370] !== 1'b0) begin miscompares++; $display("FAIL nom_busy_2370 got %b want 0", busy_hist[2370]); end
        vectors++; if (busy_hist[2426] !== 1'b1) begin miscompares++; $display("FAIL nom_busy_2426 got %b want 1", busy_hist[2426]); end
        vectors++; if (busy_hist[7175] !== 1'b1) begin miscompares++; $display("FAIL nom_busy_7175 got %b want 1", busy_hist[7175]); end
        vectors++; if (busy_hist[7176] !== 1'b0) begin miscompares++; $display("FAIL nom_busy_7176 got %b want 0", busy_hist[7176]); end
        vectors++; if (data_out !== 10'h2AA) begin miscompares++; $display("FAIL nom_hold_data_out got %h want 2aa", data_out); end
    endtask

    task automatic test_corrected();
        clear_stream();
        push_frame(8'hAA, 8'h55, 8'hAA, 8'h02, PRE, PRE, PRE, 8'h00);
        run_stream(7250, NEVER, NEVER);
        idle(2);
        vectors++; if (valid_cnt !== 1 || valid_cyc !== 7176) begin miscompares++; $display("FAIL cor_valid count %0d cycle %0d want 1 7176", valid_cnt, valid_cyc); end
        vectors++; if (v_data !== 10'h2AA) begin miscompares++; $display("FAIL cor_data_out got %h want 2aa", v_data); end
        vectors++; if (v_cor !== 1'b1) begin miscompares++; $display("FAIL cor_corrected got %b want 1", v_cor); end
        vectors++; if (v_err !== 1'b0) begin miscompares++; $display("FAIL cor_frame_error got %b want 0", v_err); end
    endtask

    task automatic test_trailer();
        clear_stream();
        push_frame(8'hAA, 8'hAA, 8'hAA, 8'h02, 8'h00, 8'h00, PRE, 8'h00);
        run_stream(7250, NEVER, NEVER);
        idle(2);
        vectors++; if (valid_cnt !== 1) begin miscompares++; $display("FAIL trl_valid_count got %0d want 1", valid_cnt); end
        vectors++; if (v_err !== 1'b1) begin miscompares++; $display("FAIL trl_frame_error got %b want 1", v_err); end
        vectors++; if (v_data !== 10'h2AA) begin miscompares++; $display("FAIL trl_data_out got %h want 2aa", v_data); end
        vectors++; if (v_cor !== 1'b1) begin miscompares++; $display("FAIL trl_corrected got %b want 1", v_cor); end
    endtask

    task automatic test_async_reset();
        clear_stream();
        push_frame(8'hAA, 8'hAA, 8'hAA, 8'h02, PRE, PRE, PRE, 8'h00);
        run_stream(4000, NEVER, NEVER);
        vectors++; if (busy !== 1'b1 || frame_error !== 1'b1) begin miscompares++; $display("FAIL ar_pre busy %b frame_error %b want 1 1", busy, frame_error); end
        #2;
        reset = 1'b1;
        #1;
        vectors++; if (data_out !== 10'h000) begin miscompares++; $display("FAIL ar_data_out got %h want 000", data_out); end
        vectors++; if (frame_error !== 1'b0 || corrected !== 1'b0) begin miscompares++; $display("FAIL ar_flags err %b cor %b want 0 0", frame_error, corrected); end
        vectors++; if (busy !== 1'b0 || data_valid !== 1'b0) begin miscompares++; $display("FAIL ar_busy_valid busy %b valid %b want 0 0", busy, data_valid); end
        enable = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        idle(2);
        run_stream(7250, NEVER, NEVER);
        idle(2);
        vectors++; if (valid_cnt !== 1 || valid_cyc !== 7176) begin miscompares++; $display("FAIL ar_after_valid count %0d cycle %0d want 1 7176", valid_cnt, valid_cyc); end
        vectors++; if (v_data !== 10'h2AA || v_err !== 1'b0) begin miscompares++; $display("FAIL ar_after_decode data %h err %b want 2aa 0", v_data, v_err); end
    endtask

    task automatic test_noise();
        clear_stream();
        for (int i = 0; i < 20; i++) push_bit(1'b0);
        push_byte(8'h5A);
        push_frame(8'hAA, 8'hAA, 8'hAA, 8'h02, PRE, PRE, PRE, 8'h00);
        run_stream(8650, NEVER, NEVER);
        idle(2);
        vectors++; if (valid_cnt !== 1 || valid_cyc !== 8576) begin miscompares++; $display("FAIL noise_valid count %0d cycle %0d want 1 8576", valid_cnt, valid_cyc); end
        vectors++; if (v_data !== 10'h2AA || v_err !== 1'b0) begin miscompares++; $display("FAIL noise_decode data %h err %b want 2aa 0", v_data, v_err); end
    endtask

    task automatic test_abort();
        int bad_cyc;
        clear_stream();
        push_frame(8'hAA, 8'hAA, 8'hAA, 8'h02, PRE, PRE, PRE, 8'h00);
        run_stream(12400, 5000, 5100);
        idle(2);
        vectors++; if (busy_hist[5000] !== 1'b1) begin miscompares++; $display("FAIL abort_busy_5000 got %b want 1", busy_hist[5000]); end
        vectors++; if (busy_hist[5001] !== 1'b0) begin miscompares++; $display("FAIL abort_busy_5001 got %b want 0", busy_hist[5001]); end
        bad_cyc = -1;
        for (int c = 5001; c <= 5100 + 2375; c++) begin
            if (busy_hist[c] !== 1'b0 && bad_cyc < 0) bad_cyc = c;
        end
        vectors++; if (bad_cyc !== -1) begin miscompares++; $display("FAIL abort_busy_low first high at cycle %0d want none", bad_cyc); end
        vectors++; if (valid_cnt !== 1 || valid_cyc !== 12276) begin miscompares++; $display("FAIL abort_valid count %0d cycle %0d want 1 12276", valid_cnt, valid_cyc); end
        vectors++; if (v_data !== 10'h2AA || v_err !== 1'b0) begin miscompares++; $display("FAIL abort_decode data %h err %b want 2aa 0", v_data, v_err); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_corrected();
        test_trailer();
        test_async_reset();
        test_noise();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
